// File: rtl/axi_ax_cut.sv
`default_nettype none
// ============================================================================
// Module   : axi_ax_cut
// Brief    : Register slice for the AXI AW and AR channels. Each cut channel
//            is carried by an independent two-slot spill buffer; W, B and R
//            pass through combinationally.
// Revision : 1.0 - initial release
// ============================================================================

// Two-slot spill buffer: slot A drives the output, slot B catches the one
// extra beat that can arrive while A is stalled. in_ready depends only on
// local state, so the ready path is cut as well as the valid/data path.
module axi_ax_cut_spill #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             a_full;
  logic             b_full;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             pop;
  logic             push;

  assign pop       = a_full & out_ready;
  assign push      = in_valid & ~b_full;
  assign out_valid = a_full;
  assign out_data  = a_data;
  assign in_ready  = ~b_full;

  // Slot update: refill A from B first, otherwise accept into A when it is
  // free or draining this cycle, otherwise park the beat in B.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_data <= '0;
      b_data <= '0;
    end else if (b_full) begin
      if (pop) begin
        a_data <= b_data;
        b_full <= 1'b0;
      end
    end else if (push) begin
      if (!a_full || pop) begin
        a_data <= in_data;
        a_full <= 1'b1;
      end else begin
        b_data <= in_data;
        b_full <= 1'b1;
      end
    end else if (pop) begin
      a_full <= 1'b0;
    end
  end

endmodule

module axi_ax_cut #(
  parameter int AXI_ADDR_WIDTH = -1,
  parameter int AXI_DATA_WIDTH = -1,
  parameter int AXI_ID_WIDTH   = -1,
  parameter int AXI_USER_WIDTH = -1,
  parameter int CUT_AW         = 1,
  parameter int CUT_AR         = 1,
  // Clamped widths keep the port declarations well formed even when the
  // parameters are left at their (invalid) defaults.
  localparam int ADDR_W = (AXI_ADDR_WIDTH > 0) ? AXI_ADDR_WIDTH : 1,
  localparam int DATA_W = (AXI_DATA_WIDTH > 0) ? AXI_DATA_WIDTH : 8,
  localparam int ID_W   = (AXI_ID_WIDTH   > 0) ? AXI_ID_WIDTH   : 1,
  localparam int USER_W = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1,
  localparam int STRB_W = (DATA_W >= 8) ? DATA_W / 8 : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // slave side (from the address-rewriting stage)
  input  logic [ID_W-1:0]   in_aw_id,
  input  logic [ADDR_W-1:0] in_aw_addr,
  input  logic [7:0]        in_aw_len,
  input  logic [2:0]        in_aw_size,
  input  logic [1:0]        in_aw_burst,
  input  logic              in_aw_lock,
  input  logic [3:0]        in_aw_cache,
  input  logic [2:0]        in_aw_prot,
  input  logic [3:0]        in_aw_qos,
  input  logic [3:0]        in_aw_region,
  input  logic [5:0]        in_aw_atop,
  input  logic [USER_W-1:0] in_aw_user,
  input  logic              in_aw_valid,
  output logic              in_aw_ready,
  input  logic [DATA_W-1:0] in_w_data,
  input  logic [STRB_W-1:0] in_w_strb,
  input  logic              in_w_last,
  input  logic [USER_W-1:0] in_w_user,
  input  logic              in_w_valid,
  output logic              in_w_ready,
  output logic [ID_W-1:0]   in_b_id,
  output logic [1:0]        in_b_resp,
  output logic [USER_W-1:0] in_b_user,
  output logic              in_b_valid,
  input  logic              in_b_ready,
  input  logic [ID_W-1:0]   in_ar_id,
  input  logic [ADDR_W-1:0] in_ar_addr,
  input  logic [7:0]        in_ar_len,
  input  logic [2:0]        in_ar_size,
  input  logic [1:0]        in_ar_burst,
  input  logic              in_ar_lock,
  input  logic [3:0]        in_ar_cache,
  input  logic [2:0]        in_ar_prot,
  input  logic [3:0]        in_ar_qos,
  input  logic [3:0]        in_ar_region,
  input  logic [USER_W-1:0] in_ar_user,
  input  logic              in_ar_valid,
  output logic              in_ar_ready,
  output logic [ID_W-1:0]   in_r_id,
  output logic [DATA_W-1:0] in_r_data,
  output logic [1:0]        in_r_resp,
  output logic              in_r_last,
  output logic [USER_W-1:0] in_r_user,
  output logic              in_r_valid,
  input  logic              in_r_ready,
  // master side (toward the interconnect)
  output logic [ID_W-1:0]   out_aw_id,
  output logic [ADDR_W-1:0] out_aw_addr,
  output logic [7:0]        out_aw_len,
  output logic [2:0]        out_aw_size,
  output logic [1:0]        out_aw_burst,
  output logic              out_aw_lock,
  output logic [3:0]        out_aw_cache,
  output logic [2:0]        out_aw_prot,
  output logic [3:0]        out_aw_qos,
  output logic [3:0]        out_aw_region,
  output logic [5:0]        out_aw_atop,
  output logic [USER_W-1:0] out_aw_user,
  output logic              out_aw_valid,
  input  logic              out_aw_ready,
  output logic [DATA_W-1:0] out_w_data,
  output logic [STRB_W-1:0] out_w_strb,
  output logic              out_w_last,
  output logic [USER_W-1:0] out_w_user,
  output logic              out_w_valid,
  input  logic              out_w_ready,
  input  logic [ID_W-1:0]   out_b_id,
  input  logic [1:0]        out_b_resp,
  input  logic [USER_W-1:0] out_b_user,
  input  logic              out_b_valid,
  output logic              out_b_ready,
  output logic [ID_W-1:0]   out_ar_id,
  output logic [ADDR_W-1:0] out_ar_addr,
  output logic [7:0]        out_ar_len,
  output logic [2:0]        out_ar_size,
  output logic [1:0]        out_ar_burst,
  output logic              out_ar_lock,
  output logic [3:0]        out_ar_cache,
  output logic [2:0]        out_ar_prot,
  output logic [3:0]        out_ar_qos,
  output logic [3:0]        out_ar_region,
  output logic [USER_W-1:0] out_ar_user,
  output logic              out_ar_valid,
  input  logic              out_ar_ready,
  input  logic [ID_W-1:0]   out_r_id,
  input  logic [DATA_W-1:0] out_r_data,
  input  logic [1:0]        out_r_resp,
  input  logic              out_r_last,
  input  logic [USER_W-1:0] out_r_user,
  input  logic              out_r_valid,
  output logic              out_r_ready
);

  // Fixed-width AXI fields: len8 size3 burst2 lock1 cache4 prot3 qos4 region4
  // (29 bits) plus atop6 on AW only.
  localparam int AW_PL_W = ID_W + ADDR_W + 35 + USER_W;
  localparam int AR_PL_W = ID_W + ADDR_W + 29 + USER_W;

  logic [AW_PL_W-1:0] aw_in_pl;
  logic [AW_PL_W-1:0] aw_out_pl;
  logic [AR_PL_W-1:0] ar_in_pl;
  logic [AR_PL_W-1:0] ar_out_pl;

  assign aw_in_pl = {in_aw_id, in_aw_addr, in_aw_len, in_aw_size, in_aw_burst,
                     in_aw_lock, in_aw_cache, in_aw_prot, in_aw_qos,
                     in_aw_region, in_aw_atop, in_aw_user};
  assign {out_aw_id, out_aw_addr, out_aw_len, out_aw_size, out_aw_burst,
          out_aw_lock, out_aw_cache, out_aw_prot, out_aw_qos, out_aw_region,
          out_aw_atop, out_aw_user} = aw_out_pl;

  assign ar_in_pl = {in_ar_id, in_ar_addr, in_ar_len, in_ar_size, in_ar_burst,
                     in_ar_lock, in_ar_cache, in_ar_prot, in_ar_qos,
                     in_ar_region, in_ar_user};
  assign {out_ar_id, out_ar_addr, out_ar_len, out_ar_size, out_ar_burst,
          out_ar_lock, out_ar_cache, out_ar_prot, out_ar_qos, out_ar_region,
          out_ar_user} = ar_out_pl;

  // AW channel: spill buffer or straight wire
  if (CUT_AW != 0) begin : g_aw_cut
    axi_ax_cut_spill #(.WIDTH(AW_PL_W)) i_aw_spill (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_valid  (in_aw_valid),
      .in_ready  (in_aw_ready),
      .in_data   (aw_in_pl),
      .out_valid (out_aw_valid),
      .out_ready (out_aw_ready),
      .out_data  (aw_out_pl)
    );
  end else begin : g_aw_bypass
    assign out_aw_valid = in_aw_valid;
    assign in_aw_ready  = out_aw_ready;
    assign aw_out_pl    = aw_in_pl;
  end

  // AR channel: spill buffer or straight wire
  if (CUT_AR != 0) begin : g_ar_cut
    axi_ax_cut_spill #(.WIDTH(AR_PL_W)) i_ar_spill (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .in_valid  (in_ar_valid),
      .in_ready  (in_ar_ready),
      .in_data   (ar_in_pl),
      .out_valid (out_ar_valid),
      .out_ready (out_ar_ready),
      .out_data  (ar_out_pl)
    );
  end else begin : g_ar_bypass
    assign out_ar_valid = in_ar_valid;
    assign in_ar_ready  = out_ar_ready;
    assign ar_out_pl    = ar_in_pl;
  end

  // W, B and R are unregistered; AW and W stay decoupled as AXI allows.
  assign out_w_data  = in_w_data;
  assign out_w_strb  = in_w_strb;
  assign out_w_last  = in_w_last;
  assign out_w_user  = in_w_user;
  assign out_w_valid = in_w_valid;
  assign in_w_ready  = out_w_ready;

  assign in_b_id     = out_b_id;
  assign in_b_resp   = out_b_resp;
  assign in_b_user   = out_b_user;
  assign in_b_valid  = out_b_valid;
  assign out_b_ready = in_b_ready;

  assign in_r_id     = out_r_id;
  assign in_r_data   = out_r_data;
  assign in_r_resp   = out_r_resp;
  assign in_r_last   = out_r_last;
  assign in_r_user   = out_r_user;
  assign in_r_valid  = out_r_valid;
  assign out_r_ready = in_r_ready;

`ifndef SYNTHESIS
  // Every width parameter must be set to a positive value by the instantiator.
  always @(posedge clk_i) begin
    assert (AXI_ADDR_WIDTH > 0 && AXI_DATA_WIDTH > 0 &&
            AXI_ID_WIDTH > 0 && AXI_USER_WIDTH > 0)
      else $error("axi_ax_cut: width parameters must be > 0");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_ax_cut.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ax_cut
// Brief    : Self-checking bench for axi_ax_cut (cut and bypass instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ax_cut;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int USER_W = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic [USER_W-1:0]   user;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // stimulus
  aw_t  aw_in;  logic aw_in_valid;  logic aw_out_ready;
  ar_t  ar_in;  logic ar_in_valid;  logic ar_out_ready;
  w_t   w_in;   logic w_in_valid;   logic w_out_ready;
  b_t   b_out;  logic b_out_valid;  logic b_in_ready;
  r_t   r_out;  logic r_out_valid;  logic r_in_ready;

  // cut instance (_c) and bypass instance (_p) outputs
  wire aw_t aw_out_c, aw_out_p;
  wire ar_t ar_out_c, ar_out_p;
  wire w_t  w_out_c,  w_out_p;
  wire b_t  b_in_c,   b_in_p;
  wire r_t  r_in_c,   r_in_p;
  wire aw_out_valid_c, aw_in_ready_c, ar_out_valid_c, ar_in_ready_c;
  wire aw_out_valid_p, aw_in_ready_p, ar_out_valid_p, ar_in_ready_p;
  wire w_out_valid_c, w_in_ready_c, b_in_valid_c, b_out_ready_c, r_in_valid_c, r_out_ready_c;
  wire w_out_valid_p, w_in_ready_p, b_in_valid_p, b_out_ready_p, r_in_valid_p, r_out_ready_p;

  axi_ax_cut #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W), .AXI_ID_WIDTH(ID_W),
               .AXI_USER_WIDTH(USER_W), .CUT_AW(1), .CUT_AR(1)) dut_cut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_aw_id(aw_in.id), .in_aw_addr(aw_in.addr), .in_aw_len(aw_in.len), .in_aw_size(aw_in.size),
    .in_aw_burst(aw_in.burst), .in_aw_lock(aw_in.lock), .in_aw_cache(aw_in.cache),
    .in_aw_prot(aw_in.prot), .in_aw_qos(aw_in.qos), .in_aw_region(aw_in.region),
    .in_aw_atop(aw_in.atop), .in_aw_user(aw_in.user), .in_aw_valid(aw_in_valid), .in_aw_ready(aw_in_ready_c),
    .in_w_data(w_in.data), .in_w_strb(w_in.strb), .in_w_last(w_in.last), .in_w_user(w_in.user),
    .in_w_valid(w_in_valid), .in_w_ready(w_in_ready_c),
    .in_b_id(b_in_c.id), .in_b_resp(b_in_c.resp), .in_b_user(b_in_c.user), .in_b_valid(b_in_valid_c), .in_b_ready(b_in_ready),
    .in_ar_id(ar_in.id), .in_ar_addr(ar_in.addr), .in_ar_len(ar_in.len), .in_ar_size(ar_in.size),
    .in_ar_burst(ar_in.burst), .in_ar_lock(ar_in.lock), .in_ar_cache(ar_in.cache),
    .in_ar_prot(ar_in.prot), .in_ar_qos(ar_in.qos), .in_ar_region(ar_in.region),
    .in_ar_user(ar_in.user), .in_ar_valid(ar_in_valid), .in_ar_ready(ar_in_ready_c),
    .in_r_id(r_in_c.id), .in_r_data(r_in_c.data), .in_r_resp(r_in_c.resp), .in_r_last(r_in_c.last),
    .in_r_user(r_in_c.user), .in_r_valid(r_in_valid_c), .in_r_ready(r_in_ready),
    .out_aw_id(aw_out_c.id), .out_aw_addr(aw_out_c.addr), .out_aw_len(aw_out_c.len), .out_aw_size(aw_out_c.size),
    .out_aw_burst(aw_out_c.burst), .out_aw_lock(aw_out_c.lock), .out_aw_cache(aw_out_c.cache),
    .out_aw_prot(aw_out_c.prot), .out_aw_qos(aw_out_c.qos), .out_aw_region(aw_out_c.region),
    .out_aw_atop(aw_out_c.atop), .out_aw_user(aw_out_c.user), .out_aw_valid(aw_out_valid_c), .out_aw_ready(aw_out_ready),
    .out_w_data(w_out_c.data), .out_w_strb(w_out_c.strb), .out_w_last(w_out_c.last), .out_w_user(w_out_c.user),
    .out_w_valid(w_out_valid_c), .out_w_ready(w_out_ready),
    .out_b_id(b_out.id), .out_b_resp(b_out.resp), .out_b_user(b_out.user), .out_b_valid(b_out_valid), .out_b_ready(b_out_ready_c),
    .out_ar_id(ar_out_c.id), .out_ar_addr(ar_out_c.addr), .out_ar_len(ar_out_c.len), .out_ar_size(ar_out_c.size),
    .out_ar_burst(ar_out_c.burst), .out_ar_lock(ar_out_c.lock), .out_ar_cache(ar_out_c.cache),
    .out_ar_prot(ar_out_c.prot), .out_ar_qos(ar_out_c.qos), .out_ar_region(ar_out_c.region),
    .out_ar_user(ar_out_c.user), .out_ar_valid(ar_out_valid_c), .out_ar_ready(ar_out_ready),
    .out_r_id(r_out.id), .out_r_data(r_out.data), .out_r_resp(r_out.resp), .out_r_last(r_out.last),
    .out_r_user(r_out.user), .out_r_valid(r_out_valid), .out_r_ready(r_out_ready_c)
  );

  axi_ax_cut #(.AXI_ADDR_WIDTH(ADDR_W), .AXI_DATA_WIDTH(DATA_W), .AXI_ID_WIDTH(ID_W),
               .AXI_USER_WIDTH(USER_W), .CUT_AW(0), .CUT_AR(0)) dut_bypass (
    .clk_i(clk), .rst_ni(rst_n),
    .in_aw_id(aw_in.id), .in_aw_addr(aw_in.addr), .in_aw_len(aw_in.len), .in_aw_size(aw_in.size),
    .in_aw_burst(aw_in.burst), .in_aw_lock(aw_in.lock), .in_aw_cache(aw_in.cache),
    .in_aw_prot(aw_in.prot), .in_aw_qos(aw_in.qos), .in_aw_region(aw_in.region),
    .in_aw_atop(aw_in.atop), .in_aw_user(aw_in.user), .in_aw_valid(aw_in_valid), .in_aw_ready(aw_in_ready_p),
    .in_w_data(w_in.data), .in_w_strb(w_in.strb), .in_w_last(w_in.last), .in_w_user(w_in.user),
    .in_w_valid(w_in_valid), .in_w_ready(w_in_ready_p),
    .in_b_id(b_in_p.id), .in_b_resp(b_in_p.resp), .in_b_user(b_in_p.user), .in_b_valid(b_in_valid_p), .in_b_ready(b_in_ready),
    .in_ar_id(ar_in.id), .in_ar_addr(ar_in.addr), .in_ar_len(ar_in.len), .in_ar_size(ar_in.size),
    .in_ar_burst(ar_in.burst), .in_ar_lock(ar_in.lock), .in_ar_cache(ar_in.cache),
    .in_ar_prot(ar_in.prot), .in_ar_qos(ar_in.qos), .in_ar_region(ar_in.region),
    .in_ar_user(ar_in.user), .in_ar_valid(ar_in_valid), .in_ar_ready(ar_in_ready_p),
    .in_r_id(r_in_p.id), .in_r_data(r_in_p.data), .in_r_resp(r_in_p.resp), .in_r_last(r_in_p.last),
    .in_r_user(r_in_p.user), .in_r_valid(r_in_valid_p), .in_r_ready(r_in_ready),
    .out_aw_id(aw_out_p.id), .out_aw_addr(aw_out_p.addr), .out_aw_len(aw_out_p.len), .out_aw_size(aw_out_p.size),
    .out_aw_burst(aw_out_p.burst), .out_aw_lock(aw_out_p.lock), .out_aw_cache(aw_out_p.cache),
    .out_aw_prot(aw_out_p.prot), .out_aw_qos(aw_out_p.qos), .out_aw_region(aw_out_p.region),
    .out_aw_atop(aw_out_p.atop), .out_aw_user(aw_out_p.user), .out_aw_valid(aw_out_valid_p), .out_aw_ready(aw_out_ready),
    .out_w_data(w_out_p.data), .out_w_strb(w_out_p.strb), .out_w_last(w_out_p.last), .out_w_user(w_out_p.user),
    .out_w_valid(w_out_valid_p), .out_w_ready(w_out_ready),
    .out_b_id(b_out.id), .out_b_resp(b_out.resp), .out_b_user(b_out.user), .out_b_valid(b_out_valid), .out_b_ready(b_out_ready_p),
    .out_ar_id(ar_out_p.id), .out_ar_addr(ar_out_p.addr), .out_ar_len(ar_out_p.len), .out_ar_size(ar_out_p.size),
    .out_ar_burst(ar_out_p.burst), .out_ar_lock(ar_out_p.lock), .out_ar_cache(ar_out_p.cache),
    .out_ar_prot(ar_out_p.prot), .out_ar_qos(ar_out_p.qos), .out_ar_region(ar_out_p.region),
    .out_ar_user(ar_out_p.user), .out_ar_valid(ar_out_valid_p), .out_ar_ready(ar_out_ready),
    .out_r_id(r_out.id), .out_r_data(r_out.data), .out_r_resp(r_out.resp), .out_r_last(r_out.last),
    .out_r_user(r_out.user), .out_r_valid(r_out_valid), .out_r_ready(r_out_ready_p)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic aw_t rand_aw(); logic [127:0] t; t = rnd128(); return t[$bits(aw_t)-1:0]; endfunction
  function automatic ar_t rand_ar(); logic [127:0] t; t = rnd128(); return t[$bits(ar_t)-1:0]; endfunction
  function automatic w_t  rand_w();  logic [127:0] t; t = rnd128(); return t[$bits(w_t)-1:0];  endfunction
  function automatic b_t  rand_b();  logic [127:0] t; t = rnd128(); return t[$bits(b_t)-1:0];  endfunction
  function automatic r_t  rand_r();  logic [127:0] t; t = rnd128(); return t[$bits(r_t)-1:0];  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each cut channel is a FIFO of capacity two that is
  // ready whenever it holds fewer than two beats and presents its oldest
  // beat one cycle after acceptance. Reset empties it at once.
  aw_t aw_q[$];
  ar_t ar_q[$];
  bit  aw_pop, aw_push, ar_pop, ar_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_q.delete();
      ar_q.delete();
    end else begin
      aw_pop  = (aw_q.size() > 0) && aw_out_ready;
      aw_push = aw_in_valid && (aw_q.size() < 2);
      ar_pop  = (ar_q.size() > 0) && ar_out_ready;
      ar_push = ar_in_valid && (ar_q.size() < 2);
      if (aw_pop)  void'(aw_q.pop_front());
      if (aw_push) aw_q.push_back(aw_in);
      if (ar_pop)  void'(ar_q.pop_front());
      if (ar_push) ar_q.push_back(ar_in);
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    chk("aw_valid", 128'(aw_out_valid_c), 128'(aw_q.size() > 0));
    chk("aw_ready", 128'(aw_in_ready_c), 128'(aw_q.size() < 2));
    if (aw_q.size() > 0) chk("aw_payload", 128'(aw_out_c), 128'(aw_q[0]));
    chk("ar_valid", 128'(ar_out_valid_c), 128'(ar_q.size() > 0));
    chk("ar_ready", 128'(ar_in_ready_c), 128'(ar_q.size() < 2));
    if (ar_q.size() > 0) chk("ar_payload", 128'(ar_out_c), 128'(ar_q[0]));
    chk("w_pass_c", 128'({w_out_c, w_out_valid_c, w_in_ready_c}), 128'({w_in, w_in_valid, w_out_ready}));
    chk("b_pass_c", 128'({b_in_c, b_in_valid_c, b_out_ready_c}), 128'({b_out, b_out_valid, b_in_ready}));
    chk("r_pass_c", 128'({r_in_c, r_in_valid_c, r_out_ready_c}), 128'({r_out, r_out_valid, r_in_ready}));
    chk("aw_bypass", 128'({aw_out_p, aw_out_valid_p, aw_in_ready_p}), 128'({aw_in, aw_in_valid, aw_out_ready}));
    chk("ar_bypass", 128'({ar_out_p, ar_out_valid_p, ar_in_ready_p}), 128'({ar_in, ar_in_valid, ar_out_ready}));
    chk("w_pass_p", 128'({w_out_p, w_out_valid_p, w_in_ready_p}), 128'({w_in, w_in_valid, w_out_ready}));
    chk("b_pass_p", 128'({b_in_p, b_in_valid_p, b_out_ready_p}), 128'({b_out, b_out_valid, b_in_ready}));
    chk("r_pass_p", 128'({r_in_p, r_in_valid_p, r_out_ready_p}), 128'({r_out, r_out_valid, r_in_ready}));
  end

  // Handshake log of the cut instance (cycle number and key field).
  int          aw_log_cyc[$];
  logic [31:0] aw_log_addr[$];
  int          ar_log_cyc[$];
  logic [3:0]  ar_log_id[$];
  always @(negedge clk) begin
    if (aw_out_valid_c && aw_out_ready) begin
      aw_log_cyc.push_back(cyc);
      aw_log_addr.push_back(aw_out_c.addr);
    end
    if (ar_out_valid_c && ar_out_ready) begin
      ar_log_cyc.push_back(cyc);
      ar_log_id.push_back(ar_out_c.id);
    end
  end

  task automatic push_ar(input logic [3:0] id);
    logic ok;
    ok = 1'b0;
    ar_in = rand_ar();
    ar_in.id = id;
    ar_in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      ok = ar_in_ready_c;
      @(posedge clk); #1;
      if (ok) break;
    end
    chk("ar_push_accept", 128'(ok), 128'(1));
    ar_in_valid = 1'b0;
  endtask

  task automatic drive_random(input bit do_aw);
    ar_in = rand_ar(); ar_in_valid = 1'($urandom_range(0, 1));
    ar_out_ready = ($urandom_range(0, 3) != 0);
    w_in  = rand_w();  w_in_valid  = 1'($urandom_range(0, 1)); w_out_ready = 1'($urandom_range(0, 1));
    b_out = rand_b();  b_out_valid = 1'($urandom_range(0, 1)); b_in_ready  = 1'($urandom_range(0, 1));
    r_out = rand_r();  r_out_valid = 1'($urandom_range(0, 1)); r_in_ready  = 1'($urandom_range(0, 1));
    if (do_aw) begin
      aw_in = rand_aw(); aw_in_valid = 1'($urandom_range(0, 1));
      aw_out_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  aw_t held;
  int  t0;
  bit  bp_done;

  initial begin
    rst_n = 1'b0;
    aw_in = rand_aw(); aw_in.addr = 32'hA000_0000; aw_in_valid = 1'b1; aw_out_ready = 1'b1;
    ar_in = '0; ar_in_valid = 1'b0; ar_out_ready = 1'b0;
    w_in = '0; w_in_valid = 1'b0; w_out_ready = 1'b0;
    b_out = '0; b_out_valid = 1'b0; b_in_ready = 1'b0;
    r_out = '0; r_out_valid = 1'b0; r_in_ready = 1'b0;

    // Reset held for three cycles with a beat offered.
    repeat (3) begin
      @(negedge clk);
      chk("rst_aw_valid", 128'(aw_out_valid_c), 128'(0));
      chk("rst_aw_ready", 128'(aw_in_ready_c), 128'(1));
      chk("rst_aw_addr",  128'(aw_out_c.addr), 128'(0));
      chk("rst_ar_valid", 128'(ar_out_valid_c), 128'(0));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lat_before_hs", 128'(aw_out_valid_c), 128'(0));
    @(posedge clk); #1 aw_in_valid = 1'b0;
    @(negedge clk);
    chk("lat_after_hs", 128'(aw_out_valid_c), 128'(1));
    chk("lat_addr", 128'(aw_out_c.addr), 128'(32'hA000_0000));
    repeat (2) @(posedge clk);

    // Streaming: 16 back-to-back AW beats.
    #1;
    aw_log_cyc.delete(); aw_log_addr.delete();
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      aw_in = rand_aw();
      aw_in.addr = 32'h1000 + 32'h40 * k;
      aw_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    aw_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("stream_count", 128'(aw_log_cyc.size()), 128'(16));
    for (int k = 0; k < 16; k++) begin
      if (k < aw_log_cyc.size()) begin
        chk("stream_cycle", 128'(aw_log_cyc[k]), 128'(t0 + 1 + k));
        chk("stream_addr",  128'(aw_log_addr[k]), 128'(32'h1000 + 32'h40 * k));
      end
    end

    // Backpressure on AR with ids 1, 2, 3.
    #1;
    ar_log_cyc.delete(); ar_log_id.delete();
    ar_out_ready = 1'b0;
    bp_done = 1'b0;
    fork
      begin push_ar(4'd1); push_ar(4'd2); push_ar(4'd3); bp_done = 1'b1; end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_ready_low", 128'(ar_in_ready_c), 128'(0));
    chk("bp_head_id",   128'(ar_out_c.id), 128'(1));
    chk("bp_no_hs",     128'(ar_log_id.size()), 128'(0));
    @(posedge clk); #1 ar_out_ready = 1'b1;
    for (int n = 0; n < 100 && !bp_done; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("bp_count", 128'(ar_log_id.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < ar_log_id.size()) begin
        chk("bp_order", 128'(ar_log_id[i]), 128'(i + 1));
        chk("bp_consecutive", 128'(ar_log_cyc[i]), 128'(ar_log_cyc[0] + i));
      end
    end
    ar_out_ready = 1'b0;

    // Stability under a 5-cycle stall with in_aw_valid withdrawn.
    @(posedge clk); #1;
    aw_out_ready = 1'b0;
    aw_in = rand_aw(); held = aw_in; aw_in_valid = 1'b1;
    @(posedge clk); #1;
    aw_in_valid = 1'b0; aw_in = rand_aw();
    aw_log_cyc.delete(); aw_log_addr.delete();
    repeat (5) begin
      @(negedge clk);
      chk("stab_valid",   128'(aw_out_valid_c), 128'(1));
      chk("stab_payload", 128'(aw_out_c), 128'(held));
    end
    @(posedge clk); #1 aw_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("stab_one_hs", 128'(aw_log_cyc.size()), 128'(1));

    // Independence: AW stalled with both slots full, other channels random.
    #1;
    aw_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      aw_in = rand_aw(); aw_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ind_aw_full", 128'(aw_in_ready_c), 128'(0));
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      drive_random(1'b0);
      if (i == 50) begin
        w_in.data = 32'hDEAD_BEEF; w_in_valid = 1'b1;
        r_out.resp = 2'b10; r_out_valid = 1'b1;
        @(negedge clk);
        chk("pt_wdata", 128'(w_out_c.data), 128'(32'hDEAD_BEEF));
        chk("pt_rresp", 128'(r_in_c.resp), 128'(2'b10));
      end
    end
    @(negedge clk);
    chk("ind_aw_still_full", 128'(aw_in_ready_c), 128'(0));

    // Fully random traffic with a mid-run reset.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      drive_random(1'b1);
      if (i == 150) rst_n = 1'b0;
      if (i == 152) rst_n = 1'b1;
    end
    @(posedge clk); #1;
    aw_in_valid = 1'b0; ar_in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
